// File: rtl/dfd_arb_pkg.sv
// Shared defaults and lane record for the multi-grant round-robin arbiter.
package dfd_arb_pkg;

  localparam int unsigned DEF_NUM_REQ    = 8;
  localparam int unsigned DEF_NUM_LANES  = 3;
  localparam int unsigned DEF_DATA_WIDTH = 4;
  localparam int unsigned DEF_IDX_W      = (DEF_NUM_REQ > 1) ? $clog2(DEF_NUM_REQ) : 1;

  typedef struct packed {
    logic                      valid;
    logic [DEF_DATA_WIDTH-1:0] data;
    logic [DEF_IDX_W-1:0]      src;
  } lane_t;

endpackage

// File: rtl/generic_ffs_N.sv
// Finds the first NUM_SEL set bits of a vector, scanning low-to-high or high-to-low.
module generic_ffs_N #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NUM_SEL = 3,
  parameter bit          DIR_L2H = 1'b1,
  parameter int unsigned IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0]                i_vec,
  output logic [NUM_SEL-1:0]              o_sel_vld_c,
  output logic [NUM_SEL-1:0][IDX_W-1:0]   o_sel_idx_c
);

  logic [WIDTH-1:0] w_rem;
  logic             w_found;

  // Each slot takes the next remaining set bit in scan order, then clears it.
  always_comb begin
    w_rem       = i_vec;
    w_found     = 1'b0;
    o_sel_vld_c = '0;
    o_sel_idx_c = '0;
    for (int j = 0; j < int'(NUM_SEL); j++) begin
      w_found = 1'b0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (!w_found && w_rem[DIR_L2H ? i : (int'(WIDTH) - 1 - i)]) begin
          w_found        = 1'b1;
          o_sel_vld_c[j] = 1'b1;
          o_sel_idx_c[j] = IDX_W'(DIR_L2H ? i : (int'(WIDTH) - 1 - i));
          w_rem[DIR_L2H ? i : (int'(WIDTH) - 1 - i)] = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/dfd_multi_grant_arb.sv
// Round-robin arbiter granting up to one requester per free output lane each cycle.
module dfd_multi_grant_arb
  import dfd_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
  parameter int unsigned NUM_LANES  = DEF_NUM_LANES,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]                   req_ready,
  output logic [NUM_LANES-1:0]                 lane_valid,
  output logic [NUM_LANES-1:0][DATA_WIDTH-1:0] lane_data,
  output logic [NUM_LANES-1:0][IDX_W-1:0]      lane_src,
  input  logic [NUM_LANES-1:0]                 lane_ready,
  output logic [15:0]                          grant_cnt
);

  localparam int unsigned SUM_W = IDX_W + 1;
  localparam int unsigned CNT_W = $clog2(NUM_LANES + 1);

  logic [NUM_LANES-1:0]                 r_lane_valid;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] r_lane_data;
  logic [NUM_LANES-1:0][IDX_W-1:0]      r_lane_src;
  logic [IDX_W-1:0]                     r_rr_ptr;
  logic [15:0]                          r_grant_cnt;

  logic [NUM_LANES-1:0]            w_free;
  logic [CNT_W-1:0]                w_free_cnt;
  logic [NUM_REQ-1:0]              w_rot;
  logic [SUM_W-1:0]                w_rot_sum;
  logic [NUM_LANES-1:0]            w_sel_vld;
  logic [NUM_LANES-1:0][IDX_W-1:0] w_sel_idx;
  logic [NUM_LANES-1:0]            w_sel_ok;
  logic [NUM_LANES-1:0][IDX_W-1:0] w_real;
  logic [SUM_W-1:0]                w_unrot_sum;
  logic [NUM_REQ-1:0]              w_req_ready;
  logic [CNT_W-1:0]                w_n_grant;
  logic [IDX_W-1:0]                w_ptr_nxt;
  logic [NUM_LANES-1:0]            w_lane_load;
  logic [NUM_LANES-1:0][IDX_W-1:0] w_lane_pick;
  logic [CNT_W-1:0]                w_prefix;
  logic [16:0]                     w_cnt_sum;

  // Free lanes and their count bound how many requesters may be granted.
  always_comb begin
    w_free     = ~r_lane_valid | lane_ready;
    w_free_cnt = '0;
    for (int k = 0; k < int'(NUM_LANES); k++) begin
      if (w_free[k]) w_free_cnt = w_free_cnt + CNT_W'(1);
    end
  end

  // Rotate requests so the round-robin pointer lands on bit 0.
  always_comb begin
    w_rot     = '0;
    w_rot_sum = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      w_rot_sum = SUM_W'(i) + {1'b0, r_rr_ptr};
      if (w_rot_sum >= SUM_W'(NUM_REQ)) w_rot_sum = w_rot_sum - SUM_W'(NUM_REQ);
      w_rot[i] = req_valid[w_rot_sum[IDX_W-1:0]];
    end
  end

  generic_ffs_N #(
    .WIDTH   (NUM_REQ),
    .NUM_SEL (NUM_LANES),
    .DIR_L2H (1'b1),
    .IDX_W   (IDX_W)
  ) u_ffs (
    .i_vec       (w_rot),
    .o_sel_vld_c (w_sel_vld),
    .o_sel_idx_c (w_sel_idx)
  );

  // Un-rotate selections, drop those beyond the free-lane count, advance pointer.
  always_comb begin
    w_sel_ok    = '0;
    w_real      = '0;
    w_unrot_sum = '0;
    w_req_ready = '0;
    w_n_grant   = '0;
    w_ptr_nxt   = r_rr_ptr;
    for (int j = 0; j < int'(NUM_LANES); j++) begin
      w_unrot_sum = {1'b0, w_sel_idx[j]} + {1'b0, r_rr_ptr};
      if (w_unrot_sum >= SUM_W'(NUM_REQ)) w_unrot_sum = w_unrot_sum - SUM_W'(NUM_REQ);
      w_real[j]   = w_unrot_sum[IDX_W-1:0];
      w_sel_ok[j] = w_sel_vld[j] && (CNT_W'(j) < w_free_cnt);
      if (w_sel_ok[j]) begin
        w_req_ready[w_real[j]] = 1'b1;
        w_n_grant              = w_n_grant + CNT_W'(1);
        w_ptr_nxt              = (w_real[j] == IDX_W'(NUM_REQ - 1)) ? '0 : w_real[j] + IDX_W'(1);
      end
    end
  end

  // The j-th grant goes to the free lane preceded by exactly j free lanes.
  always_comb begin
    w_lane_load = '0;
    w_lane_pick = '0;
    w_prefix    = '0;
    for (int k = 0; k < int'(NUM_LANES); k++) begin
      if (w_free[k]) begin
        for (int j = 0; j < int'(NUM_LANES); j++) begin
          if ((CNT_W'(j) == w_prefix) && w_sel_ok[j]) begin
            w_lane_load[k] = 1'b1;
            w_lane_pick[k] = w_real[j];
          end
        end
        w_prefix = w_prefix + CNT_W'(1);
      end
    end
  end

  assign w_cnt_sum = {1'b0, r_grant_cnt} + 17'(w_n_grant);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lane_valid <= '0;
      r_lane_data  <= '0;
      r_lane_src   <= '0;
      r_rr_ptr     <= '0;
      r_grant_cnt  <= '0;
    end else begin
      for (int k = 0; k < int'(NUM_LANES); k++) begin
        if (w_free[k]) begin
          r_lane_valid[k] <= w_lane_load[k];
          if (w_lane_load[k]) begin
            r_lane_data[k] <= req_data[w_lane_pick[k]];
            r_lane_src[k]  <= w_lane_pick[k];
          end
        end
      end
      r_rr_ptr    <= w_ptr_nxt;
      r_grant_cnt <= w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
    end
  end

  assign req_ready  = reset ? '0 : w_req_ready;
  assign lane_valid = r_lane_valid;
  assign lane_data  = r_lane_data;
  assign lane_src   = r_lane_src;
  assign grant_cnt  = r_grant_cnt;

endmodule

// File: tb/tb_dfd_multi_grant_arb.sv
// Scoreboard bench: a list-based round-robin model predicts grants, lane contents and counts.
module tb_dfd_multi_grant_arb;
  import dfd_arb_pkg::*;

  localparam int NR = int'(DEF_NUM_REQ);
  localparam int NL = int'(DEF_NUM_LANES);
  localparam int DW = int'(DEF_DATA_WIDTH);
  localparam int IW = int'(DEF_IDX_W);

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NR-1:0]          req_valid;
  logic [NR-1:0][DW-1:0]  req_data;
  logic [NR-1:0]          req_ready;
  logic [NL-1:0]          lane_valid;
  logic [NL-1:0][DW-1:0]  lane_data;
  logic [NL-1:0][IW-1:0]  lane_src;
  logic [NL-1:0]          lane_ready;
  logic [15:0]            grant_cnt;

  always #5 clk = ~clk;

  dfd_multi_grant_arb dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .lane_valid (lane_valid),
    .lane_data  (lane_data),
    .lane_src   (lane_src),
    .lane_ready (lane_ready),
    .grant_cnt  (grant_cnt)
  );

  int checks   = 0;
  int failures = 0;

  lane_t         exp_q [NL][$];
  logic [NR-1:0] q_ready[$];
  logic [NL-1:0] q_valid[$];
  logic [15:0]   q_cnt[$];

  logic [NL-1:0] m_busy = '0;
  int            m_rr   = 0;
  int            m_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; the model predicts what the DUT must show this cycle and load next.
  task automatic step(input logic rst, input logic [NR-1:0] rv, input logic [NL-1:0] lr);
    int            fl[$];
    int            sel[$];
    logic [NR-1:0] rdy;
    lane_t         it;
    @(posedge clk);
    #1;
    reset      = rst;
    req_valid  = rv;
    lane_ready = rst ? '0 : lr;
    for (int i = 0; i < NR; i++) req_data[i] = DW'($urandom);
    q_valid.push_back(m_busy);
    q_cnt.push_back(16'(m_cnt));
    rdy = '0;
    if (rst) begin
      for (int k = 0; k < NL; k++) exp_q[k].delete();
      m_busy = '0;
      m_rr   = 0;
      m_cnt  = 0;
    end else begin
      for (int k = 0; k < NL; k++) begin
        if (!m_busy[k] || lr[k]) begin
          fl.push_back(k);
          m_busy[k] = 1'b0;
        end
      end
      for (int s = 0; s < NR; s++) begin
        int i;
        i = (m_rr + s) % NR;
        if (rv[i] && sel.size() < fl.size()) sel.push_back(i);
      end
      for (int j = 0; j < sel.size(); j++) begin
        it.valid = 1'b1;
        it.data  = req_data[sel[j]];
        it.src   = IW'(sel[j]);
        rdy[sel[j]]   = 1'b1;
        m_busy[fl[j]] = 1'b1;
        exp_q[fl[j]].push_back(it);
      end
      if (sel.size() > 0) m_rr = (sel[sel.size()-1] + 1) % NR;
      m_cnt = (m_cnt + sel.size() > 65535) ? 65535 : m_cnt + sel.size();
    end
    q_ready.push_back(rdy);
  endtask

  // Monitor: compares each cycle's DUT view and every downstream lane handshake.
  initial begin : mon
    lane_t it;
    forever begin
      @(negedge clk);
      if (q_ready.size() > 0) begin
        chk("req_ready",  32'(req_ready),  32'(q_ready.pop_front()));
        chk("lane_valid", 32'(lane_valid), 32'(q_valid.pop_front()));
        chk("grant_cnt",  32'(grant_cnt),  32'(q_cnt.pop_front()));
        for (int k = 0; k < NL; k++) begin
          if (lane_valid[k] && lane_ready[k]) begin
            if (exp_q[k].size() == 0) begin
              checks++;
              failures++;
              $display("FAIL lane%0d_unexpected actual=src%0d required=none @%0t", k, lane_src[k], $time);
            end else begin
              it = exp_q[k].pop_front();
              chk($sformatf("lane%0d_data", k), 32'(lane_data[k]), 32'(it.data));
              chk($sformatf("lane%0d_src", k),  32'(lane_src[k]),  32'(it.src));
            end
          end
        end
      end
    end
  end

  initial begin
    reset      = 1'b1;
    req_valid  = '0;
    req_data   = '0;
    lane_ready = '0;

    step(1'b1, '0, '0);
    step(1'b1, '0, '0);
    // Full request set, all lanes draining: 0,1,2 then 3,4,5 then 6,7,0.
    repeat (4) step(1'b0, 8'hFF, 3'b111);

    // Lanes 0,2 stalled with lane 1 free and pointer back at 0.
    step(1'b1, '0, '0);
    step(1'b0, 8'b1000_0011, 3'b111);
    step(1'b0, 8'h0F, 3'b010);
    step(1'b0, 8'h00, 3'b111);

    // Pointer at 6, wrap-around grants 6,7,0.
    step(1'b1, '0, '0);
    step(1'b0, 8'h20, 3'b111);
    step(1'b0, 8'b1100_0001, 3'b111);
    step(1'b0, 8'h00, 3'b111);

    // All lanes stalled for five cycles under full request load.
    step(1'b0, 8'hFF, 3'b111);
    repeat (5) step(1'b0, 8'hFF, 3'b000);
    step(1'b0, 8'h00, 3'b111);

    repeat (400) begin
      logic [NR-1:0] rv;
      rv = ($urandom_range(0, 4) == 0) ? '0 : NR'($urandom);
      step(1'b0, rv, NL'($urandom));
    end

    // Reset while lanes hold data and requests are pending.
    step(1'b0, 8'hFF, 3'b000);
    step(1'b1, 8'hFF, 3'b111);
    step(1'b1, 8'hFF, 3'b111);
    step(1'b0, 8'h00, 3'b111);

    // Drive the counter to 16'hFFFE, then a 3-grant cycle must saturate it.
    repeat (21844) step(1'b0, 8'hFF, 3'b111);
    step(1'b0, 8'h03, 3'b111);
    repeat (3) step(1'b0, 8'hFF, 3'b111);
    repeat (2) step(1'b0, 8'h00, 3'b111);

    @(negedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dfd_multi_grant_arb.md
DFD_MULTI_GRANT_ARB -- requirements
Module: dfd_multi_grant_arb

Interface
REQ-001 Parameter NUM_REQ, default 8, SHALL be the number of requesters (min 2).
REQ-002 Parameter NUM_LANES, default 3, SHALL be the number of output lanes (1..NUM_REQ).
REQ-003 Parameter DATA_WIDTH, default 4, SHALL be the payload width per requester.
REQ-004 Parameter IDX_W, default max($clog2(NUM_REQ),1), SHALL be the requester-index width.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  SHALL be the single clock; all state on rising edge.
REQ-007 reset  input  1  SHALL be the synchronous active-high reset.
REQ-008 req_valid  input  NUM_REQ  SHALL be the per-requester valid.
REQ-009 req_data  input  NUM_REQ x DATA_WIDTH  SHALL be the per-requester payload.
REQ-010 req_ready  output  NUM_REQ  SHALL be the per-requester accept, combinational.
REQ-011 lane_valid  output  NUM_LANES  SHALL be the registered lane valid.
REQ-012 lane_data  output  NUM_LANES x DATA_WIDTH  SHALL be the registered lane payload.
REQ-013 lane_src  output  NUM_LANES x IDX_W  SHALL be the registered source index of the lane payload.
REQ-014 lane_ready  input  NUM_LANES  SHALL be the per-lane downstream accept.
REQ-015 grant_cnt  output  16  SHALL be the saturating count of accepted requests.

Function
REQ-016 Lane k SHALL be free in a cycle when lane_valid[k]=0 or lane_ready[k]=1; F = number of free lanes.
REQ-017 Each cycle the block SHALL select min(F, popcount(req_valid)) requesters, in round-robin order starting at pointer rr_ptr and ascending with wrap (rr_ptr, rr_ptr+1, ..., NUM_REQ-1, 0, ...).
REQ-018 The j-th selected requester (j=0 first in priority) SHALL be assigned to the j-th free lane in ascending lane index.
REQ-019 req_ready[i] SHALL be 1 iff requester i is selected; a transfer occurs when req_valid[i] & req_ready[i]; req_ready SHALL be 0 for non-valid requesters.
REQ-020 An assigned lane SHALL load lane_data=req_data[i], lane_src=i, lane_valid=1 on the next edge (latency 1 cycle, full throughput).
REQ-021 A free lane not assigned SHALL clear lane_valid on the next edge; a non-free lane SHALL hold lane_valid, lane_data, lane_src unchanged.
REQ-022 If at least one grant occurs, rr_ptr SHALL update to (index of last-priority granted requester + 1) mod NUM_REQ; otherwise rr_ptr SHALL hold.
REQ-023 With F=0 (all lanes stalled) no req_ready SHALL assert and rr_ptr SHALL hold.
REQ-024 With no req_valid, no lane SHALL load and rr_ptr SHALL hold.
REQ-025 grant_cnt SHALL add the number of transfers each cycle and saturate at 16'hFFFF.
REQ-026 A requester SHALL receive at most one grant per cycle; no requester SHALL wait more than ceil(NUM_REQ/NUM_LANES) cycles with F=NUM_LANES every cycle.

Reset
REQ-027 Under reset: lane_valid=0, lane_data=0, lane_src=0, rr_ptr=0, grant_cnt=0, req_ready=0.
REQ-028 Reset mid-operation SHALL drop in-flight lane contents; reset SHALL take priority over any grant in the same cycle.

Structure
REQ-029 Package dfd_arb_pkg SHALL hold the default parameter constants and the lane record typedef (valid, data, src).
REQ-030 Selection SHALL reuse generic_ffs_N (DIR_L2H=1, NUM_SEL=NUM_LANES) on the request vector rotated by rr_ptr, with index un-rotation (mod NUM_REQ) after selection; no other sub-module.
REQ-031 The F-limit SHALL be applied by masking selector outputs j>=F; lane mapping SHALL use a prefix count of free lanes.

Verification
REQ-032 Reset, req_valid=8'hFF, all lane_ready=1 -> cycle 1 grants req 0,1,2 to lanes 0,1,2; rr_ptr=3; cycle 2 grants 3,4,5; cycle 3 grants 6,7,0.
REQ-033 rr_ptr=6, req_valid=8'b1100_0001 -> grants 6,7,0 on lanes 0,1,2; rr_ptr becomes 1 (wrap).
REQ-034 Lanes 0,2 valid and stalled, lane 1 free, req_valid=8'h0F, rr_ptr=0 -> only req 0 ready, lands on lane 1; lanes 0,2 data unchanged.
REQ-035 All lanes stalled 5 cycles with req_valid=8'hFF -> req_ready=0, rr_ptr constant, grant_cnt constant.
REQ-036 grant_cnt preset to 16'hFFFE, 3 grants in one cycle -> grant_cnt=16'hFFFF.
REQ-037 Reset asserted while lanes valid and requests pending -> next cycle lane_valid=0, rr_ptr=0, grant_cnt=0, no req_ready.
